// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with PC ownership, imem req/ack handshake,
//            single-entry hold buffer, redirect/flush and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4,
  output logic        instValid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_DRAIN = 2'b10,
    S_HOLD  = 2'b11
  } state_t;

  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] C_STEP      = 32'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        inst_valid_q, inst_valid_d;
  logic        imem_req_q, imem_req_d;

  logic [31:0] redirect_pc_w;
  logic [31:0] pc_next_w;
  logic        ack_w;

  // Low address bits of the redirect target are dropped to stay word aligned.
  assign redirect_pc_w = redirectPc & C_WORD_MASK;
  assign pc_next_w     = pc_q + C_STEP;
  // An ack only counts while a request is actually outstanding.
  assign ack_w         = imem_req_q & imemAck;

  // Next-state, PC, hold buffer and IF/ID computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    pc_plus4_d   = pc_plus4_q;
    inst_valid_d = inst_valid_q;

    // Decode consuming with nothing new arriving leaves a bubble.
    if (!stall) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc_w;
        end
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          if (ack_w) begin
            pc_d    = redirect_pc_w;
            state_d = S_REQ;
          end else begin
            // Request must complete at the old address before retargeting.
            target_d = redirect_pc_w;
            state_d  = S_DRAIN;
          end
        end else if (ack_w) begin
          pc_d = pc_next_w;
          if (!stall) begin
            inst_d       = imemData;
            pc_out_d     = pc_q;
            pc_plus4_d   = pc_next_w;
            inst_valid_d = 1'b1;
            state_d      = S_REQ;
          end else begin
            buf_inst_d = imemData;
            buf_pc_d   = pc_q;
            state_d    = S_HOLD;
          end
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          target_d = redirect_pc_w;
        end
        if (ack_w) begin
          // Newest redirect target wins even when it lands with the ack.
          pc_d    = redirect ? redirect_pc_w : target_q;
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc_w;
          state_d = S_REQ;
        end else if (!stall) begin
          inst_d       = buf_inst_q;
          pc_out_d     = buf_pc_q;
          pc_plus4_d   = buf_pc_q + C_STEP;
          inst_valid_d = 1'b1;
          state_d      = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides both delivery and stall.
    if (redirect) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end

    imem_req_d = (state_d == S_REQ) || (state_d == S_DRAIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      target_q     <= 32'h0;
      buf_inst_q   <= 32'h0;
      buf_pc_q     <= 32'h0;
      inst_q       <= NOP_INST;
      pc_out_q     <= 32'h0;
      pc_plus4_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      pc_plus4_q   <= pc_plus4_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imemReq   = imem_req_q;
  assign imemAddr  = pc_q & C_WORD_MASK;
  assign inst      = inst_q;
  assign pcOut     = pc_out_q;
  assign pcPlus4   = pc_plus4_q;
  assign instValid = inst_valid_q;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with a built-in IF/ID pipeline register. It feeds the decode/register-read stage: its `inst` output drives the rs/rt/rd/funct split and the register bank.
- Owns the PC and talks to instruction memory over a req/ack handshake. Supports decode stall, a single-entry hold buffer, and PC redirect (branch/jump) with flush.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000000, instruction word driven on inst when no valid instruction is held

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
stall  input  1  decode cannot accept; IF/ID register must hold
redirect  input  1  load redirectPc, flush in-flight/held instructions
redirectPc  input  32  redirect target; bits [1:0] ignored (forced 00)
imemReq  output  1  fetch request to instruction memory
imemAddr  output  32  word-aligned fetch address; valid while imemReq=1
imemAck  input  1  memory returns imemData this cycle (meaningful only while imemReq=1)
imemData  input  32  instruction word, sampled when imemReq&&imemAck
inst  output  32  IF/ID instruction
pcOut  output  32  IF/ID PC of inst
pcPlus4  output  32  IF/ID pcOut+4
instValid  output  1  inst/pcOut/pcPlus4 hold a real instruction

Behaviour:
- All state updates on rising clk. rst is sampled synchronously and overrides everything, including redirect and an in-flight fetch.
- Reset values: pc=RESET_PC, state=IDLE, imemReq=0, inst=NOP_INST, pcOut=0, pcPlus4=0, instValid=0, hold buffer empty.
- States: IDLE, REQ, DRAIN, HOLD. The state register is 2 bits and is fully encoded.
- IDLE: imemReq=0. Lasts exactly 1 cycle after reset, then goes to REQ. Redirect in IDLE loads pc and goes to REQ.
- REQ: imemReq=1, imemAddr=pc. The address must stay stable until ack. Transitions, by condition:
  - No ack, no redirect: stay in REQ.
  - Ack, no redirect, stall=0: IF/ID <= {imemData, pc, pc+4}, instValid<=1, pc<=pc+4, stay in REQ (back-to-back fetch).
  - Ack, no redirect, stall=1: buffer <= {imemData, pc}, pc<=pc+4, go to HOLD. IF/ID is unchanged.
  - Redirect with ack in the same cycle: discard imemData, pc<=redirectPc, go to REQ.
  - Redirect without ack: record the target, go to DRAIN. imemReq stays 1 with the old address.
- DRAIN: imemReq=1 at the old address.
  - On ack: discard the data, pc<=recorded target, go to REQ.
  - A new redirect in DRAIN overwrites the recorded target (last wins).
- HOLD: imemReq=0.
  - When stall=0: IF/ID <= buffer, instValid<=1, go to REQ.
  - Redirect in HOLD: discard the buffer, pc<=redirectPc, go to REQ.
- IF/ID register update rules:
  - stall=1: inst/pcOut/pcPlus4/instValid hold.
  - stall=0, no instruction delivered this cycle: instValid<=0 and inst<=NOP_INST. pcOut/pcPlus4 may hold.
  - redirect=1: instValid<=0 and inst<=NOP_INST next cycle regardless of stall (flush wins over stall).
- Latency: ack at cycle N with stall=0 → instValid=1 at N+1. Zero-wait memory sustains 1 instruction/cycle.
- Arithmetic: pc and pcPlus4 wrap modulo 2^32 (32'hFFFFFFFC+4 = 0). No overflow flag.
- imemAddr is always driven as {pc[31:2],2'b00}.
- Simultaneous-event priority: rst > redirect > ack > stall.

Test Plan:
- Reset/ordering: rst=1 for 2 cycles, then memory with zero-wait ack and data = address → imemReq rises 1 cycle after rst drops; inst = 0, 4, 8, ... on consecutive cycles with instValid=1; pcPlus4 = pcOut+4.
- Wait states: ack delayed 3 cycles per request → imemAddr stable across the wait; one instValid=1 cycle per ack, instValid=0 between.
- Stall/hold: stall=1 asserted while ack for addr 0x10 arrives → IF/ID keeps the previous instruction; state HOLD, imemReq=0; release stall → inst=data@0x10, pcOut=0x10, then the fetch of 0x14 begins.
- Redirect mid-wait: redirect to 0x103 while the request at 0x20 is unacked → imemAddr stays 0x20 until ack; that data is dropped; next imemAddr=0x100; instValid=0 until data@0x100 is delivered.
- Redirect with ack, with stall: redirect=1 and ack in the same cycle, stall=1 → next cycle instValid=0, inst=NOP_INST, imemAddr=redirect target.
- Reset mid-op and PC wrap: rst in HOLD → all outputs at reset values next cycle. Separately, redirect to 0xFFFFFFFC → pcPlus4=0 and the next imemAddr=0.
